// File: rtl/led_status_pkg.sv
// Shared types and defaults for the front-panel LED status controller.
package led_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_VEND  = 2'd2,
    ST_DENY  = 2'd3
  } led_state_e;

  localparam int          DEF_TICK_DIV    = 50000;
  localparam int          DEF_SLOW_TICKS  = 500;
  localparam int          DEF_FAST_TICKS  = 125;
  localparam int          DEF_VEND_HALVES = 6;
  localparam int          DEF_DENY_HALVES = 4;
  localparam logic [15:0] DEF_PRICE       = 16'h0300;

  localparam int KEY_VEND   = 3;
  localparam int KEY_CANCEL = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV sclk cycles.
module led_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic sclk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/led_status_ctrl.sv
// Credit-vs-price LED controller: idle chaser, steady ready, timed vend/deny flashes.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int          N_LED       = 4,
  parameter int          TICK_DIV    = DEF_TICK_DIV,
  parameter int          SLOW_TICKS  = DEF_SLOW_TICKS,
  parameter int          FAST_TICKS  = DEF_FAST_TICKS,
  parameter int          VEND_HALVES = DEF_VEND_HALVES,
  parameter int          DENY_HALVES = DEF_DENY_HALVES,
  parameter logic [15:0] PRICE       = DEF_PRICE,
  parameter bit          IDLE_CHASE  = 1'b1
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic [3:0]       flag_key,
  input  logic [23:0]      rNum,
  output logic [N_LED-1:0] led,
  output logic             busy
);

  localparam int HALF_MAX   = max_int(SLOW_TICKS, FAST_TICKS);
  localparam int TW         = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int HALVES_MAX = max_int(VEND_HALVES, DENY_HALVES);
  localparam int HW         = (HALVES_MAX > 1) ? $clog2(HALVES_MAX) : 1;
  localparam int CW         = (SLOW_TICKS > 1) ? $clog2(SLOW_TICKS) : 1;

  localparam logic [TW-1:0] SLOW_LAST = TW'(SLOW_TICKS - 1);
  localparam logic [TW-1:0] FAST_LAST = TW'(FAST_TICKS - 1);
  localparam logic [HW-1:0] VEND_LAST = HW'(VEND_HALVES - 1);
  localparam logic [HW-1:0] DENY_LAST = HW'(DENY_HALVES - 1);
  localparam logic [CW-1:0] CHASE_LAST = CW'(SLOW_TICKS - 1);

  function automatic logic [N_LED-1:0] even_mask();
    logic [N_LED-1:0] m;
    m = '0;
    for (int i = 0; i < N_LED; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [N_LED-1:0] EVEN_LEDS = even_mask();

  logic tick;
  logic ready;

  led_state_e       state_q, state_d, exit_st;
  logic [TW-1:0]    tcnt_q, tcnt_d, half_last;
  logic [HW-1:0]    halves_q, halves_d, halves_last;
  logic             phase_q, phase_d;
  logic [N_LED-1:0] chase_q, chase_d;
  logic [CW-1:0]    ccnt_q, ccnt_d;
  logic [N_LED-1:0] led_d;
  logic             busy_d;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sclk  (sclk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Both operands are legal BCD, so a binary compare orders them correctly.
  assign ready = (rNum[23:8] >= PRICE);

  // Chaser runs in every state so IDLE resumes wherever it happens to be.
  always_comb begin
    chase_d = chase_q;
    ccnt_d  = ccnt_q;
    if (tick) begin
      if (ccnt_q == CHASE_LAST) begin
        ccnt_d  = '0;
        chase_d = {chase_q[N_LED-2:0], chase_q[N_LED-1]};
      end else begin
        ccnt_d = ccnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    halves_d    = halves_q;
    phase_d     = phase_q;
    exit_st     = ready ? ST_READY : ST_IDLE;
    half_last   = (state_q == ST_VEND) ? FAST_LAST : SLOW_LAST;
    halves_last = (state_q == ST_VEND) ? VEND_LAST : DENY_LAST;

    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          state_d = ST_READY;
        end else if (flag_key[KEY_VEND]) begin
          state_d  = ST_DENY;
          tcnt_d   = '0;
          halves_d = '0;
          phase_d  = 1'b1;
        end
      end
      ST_READY: begin
        if (flag_key[KEY_VEND]) begin
          state_d  = ST_VEND;
          tcnt_d   = '0;
          halves_d = '0;
          phase_d  = 1'b1;
        end else if (!ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_VEND, ST_DENY: begin
        // Cancel beats everything; a repeated vend key is deliberately ignored.
        if (flag_key[KEY_CANCEL]) begin
          state_d = exit_st;
        end else if (tick) begin
          if (tcnt_q == half_last) begin
            tcnt_d  = '0;
            phase_d = ~phase_q;
            if (halves_q == halves_last) begin
              state_d = exit_st;
            end else begin
              halves_d = halves_q + HW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_IDLE:  led_d = IDLE_CHASE ? chase_d : '0;
      ST_READY: led_d = '1;
      ST_VEND:  led_d = phase_d ? '1 : '0;
      ST_DENY:  led_d = phase_d ? EVEN_LEDS : ~EVEN_LEDS;
      default:  led_d = '0;
    endcase
    busy_d = (state_d == ST_VEND) || (state_d == ST_DENY);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tcnt_q   <= '0;
      halves_q <= '0;
      phase_q  <= 1'b0;
      chase_q  <= N_LED'(1);
      ccnt_q   <= '0;
      led      <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      halves_q <= halves_d;
      phase_q  <= phase_d;
      chase_q  <= chase_d;
      ccnt_q   <= ccnt_d;
      led      <= led_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: directed scenarios plus random keys/credit against a tick-count model.
module tb_led_status_ctrl;

  localparam int          N_LED       = 4;
  localparam int          TICK_DIV    = 4;
  localparam int          SLOW_TICKS  = 4;
  localparam int          FAST_TICKS  = 2;
  localparam int          VEND_HALVES = 6;
  localparam int          DENY_HALVES = 4;
  localparam logic [15:0] PRICE       = 16'h0300;
  localparam int          W           = N_LED + 1;

  logic             sclk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       flag_key = '0;
  logic [23:0]      rNum = '0;
  logic [N_LED-1:0] led;
  logic             busy;

  always #5 sclk = ~sclk;

  led_status_ctrl #(
    .N_LED       (N_LED),
    .TICK_DIV    (TICK_DIV),
    .SLOW_TICKS  (SLOW_TICKS),
    .FAST_TICKS  (FAST_TICKS),
    .VEND_HALVES (VEND_HALVES),
    .DENY_HALVES (DENY_HALVES),
    .PRICE       (PRICE),
    .IDLE_CHASE  (1'b1)
  ) dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .flag_key (flag_key),
    .rNum     (rNum),
    .led      (led),
    .busy     (busy)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp_v, $time);
    end
  endtask

  // Model: mode plus the number of edges since reset and ticks since flash entry.
  localparam int M_IDLE = 0, M_READY = 1, M_VEND = 2, M_DENY = 3;
  int m_state, m_k, m_n;

  task automatic model_reset();
    m_state = M_IDLE;
    m_k     = 0;
    m_n     = 0;
  endtask

  function automatic logic [N_LED-1:0] model_led();
    logic [N_LED-1:0] one, even;
    int r;
    one  = 1;
    even = '0;
    for (int i = 0; i < N_LED; i += 2) even[i] = 1'b1;
    case (m_state)
      M_IDLE: begin
        r = ((m_k / TICK_DIV) / SLOW_TICKS) % N_LED;
        return one << r;
      end
      M_READY: return '1;
      M_VEND:  return (((m_n / FAST_TICKS) % 2) == 0) ? '1 : '0;
      default: return (((m_n / SLOW_TICKS) % 2) == 0) ? even : ~even;
    endcase
  endfunction

  task automatic model_edge(input logic [3:0] key, input logic [23:0] rn);
    bit rdy, tk;
    int total;
    rdy = (rn[23:8] >= PRICE);
    m_k++;
    tk = ((m_k % TICK_DIV) == 0);
    case (m_state)
      M_IDLE: begin
        if (rdy) m_state = M_READY;
        else if (key[3]) begin m_state = M_DENY; m_n = 0; end
      end
      M_READY: begin
        if (key[3]) begin m_state = M_VEND; m_n = 0; end
        else if (!rdy) m_state = M_IDLE;
      end
      default: begin
        total = (m_state == M_VEND) ? VEND_HALVES * FAST_TICKS : DENY_HALVES * SLOW_TICKS;
        if (key[0]) m_state = rdy ? M_READY : M_IDLE;
        else if (tk) begin
          m_n++;
          if (m_n == total) m_state = rdy ? M_READY : M_IDLE;
        end
      end
    endcase
    exp_q.push_back({(m_state >= M_VEND), model_led()});
  endtask

  // Called just after a negedge: drive, let the DUT sample, compare #1 later.
  task automatic step(input logic [3:0] key, input logic [23:0] rn, input string tag);
    logic [W-1:0] exp_v;
    flag_key = key;
    rNum     = rn;
    @(posedge sclk);
    model_edge(key, rn);
    #1;
    exp_v = exp_q.pop_front();
    check_eq(tag, {busy, led}, exp_v);
    @(negedge sclk);
    flag_key = '0;
  endtask

  task automatic run(input int n, input logic [23:0] rn, input string tag);
    repeat (n) step(4'b0000, rn, tag);
  endtask

  function automatic logic [23:0] rand_credit();
    logic [23:0] v;
    for (int i = 0; i < 6; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 3) != 0) begin
      v[23:16] = 8'h00;
      v[15:12] = 4'($urandom_range(2, 3));
    end
    return v;
  endfunction

  initial begin
    logic [23:0] rn;
    logic [3:0]  key;

    model_reset();
    #12;
    check_eq("reset_led", {28'd0, led}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge sclk);
    rst_n = 1'b1;

    run(70, 24'h000000, "idle_chase");

    run(4, 24'h000300, "ready_enter");
    run(4, 24'h000299, "ready_leave");

    run(3, 24'h000300, "pre_vend");
    step(4'b1000, 24'h000300, "vend_start");
    run(55, 24'h000300, "vend_flash");

    run(4, 24'h000000, "pre_deny");
    step(4'b1000, 24'h000000, "deny_start");
    run(75, 24'h000000, "deny_flash");

    run(3, 24'h000400, "pre_abort");
    step(4'b1000, 24'h000400, "abort_vend");
    run(9, 24'h000400, "abort_mid");
    step(4'b1001, 24'h000400, "abort_cancel");
    run(5, 24'h000400, "abort_after");

    step(4'b1000, 24'h000300, "rekey_vend");
    run(11, 24'h000300, "rekey_mid");
    step(4'b1000, 24'h000300, "rekey_again");
    run(45, 24'h000150, "rekey_rest");

    rn = 24'h000000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) rn = rand_credit();
      key = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      step(key, rn, "random");
    end

    run(4, 24'h000000, "pre_rst_deny");
    step(4'b1000, 24'h000000, "rst_deny_start");
    run(10, 24'h000000, "rst_deny_mid");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_led", {28'd0, led}, 32'd0);
    check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    run(40, 24'h000000, "post_rst_chase");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_status_ctrl.md
# led_status_ctrl

Parametrised front-panel LED controller for the vending machine, successor to the fixed 4-LED credit indicator. It compares the BCD credit against a configurable price and drives N_LED channels in one of five patterns: off, idle chaser, steady ready, vend flash and deny flash. Vend and deny flashes run for a fixed number of half-periods, then return to the credit-derived state. It sits between the key debouncer/credit counter and the board LED pins.

## Interface
- N_LED, 4: number of LED channels, ≥2
- TICK_DIV, 50000: sclk cycles per tick (1 ms at 50 MHz)
- SLOW_TICKS, 500: half-period of slow blink/chaser step, in ticks
- FAST_TICKS, 125: half-period of fast blink, in ticks
- VEND_HALVES, 6: half-periods shown in vend flash
- DENY_HALVES, 4: half-periods shown in deny flash
- PRICE, 16'h0300: price in BCD, compared with rNum[23:8]
- IDLE_CHASE, 1: 1 = chaser in IDLE, 0 = LEDs off in IDLE
- sclk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- flag_key  in  4  one-cycle key pulses; [3] = vend request, [0] = cancel, [2:1] unused
- rNum  in  24  credit, 6 BCD digits
- led  out  N_LED  LED drive, 1 = lit
- busy  out  1  high while in VEND or DENY

## Operation
- ready = (rNum[23:8] >= PRICE), as an unsigned compare. This is valid because both operands are legal BCD. rNum[7:0] is ignored.
- States: IDLE, READY, VEND, DENY.
- IDLE:
  - ready → READY.
  - flag_key[3] → DENY.
  - led = one-hot chaser if IDLE_CHASE, else 0. The chaser starts at bit 0 and rotates left one position every SLOW_TICKS ticks, wrapping from bit N_LED-1 to bit 0.
- READY:
  - led = all ones.
  - !ready → IDLE.
  - flag_key[3] → VEND. The key takes priority over a same-cycle credit drop.
- VEND:
  - Entry sets phase = 1 and clears the half-period and tick counters.
  - led = phase ? all ones : 0. Phase toggles every FAST_TICKS ticks.
  - After VEND_HALVES half-periods, go to READY if ready, else IDLE.
- DENY:
  - led = phase ? even-index channels : odd-index channels. On entry phase = 1. Toggle every SLOW_TICKS ticks.
  - Exit after DENY_HALVES half-periods, same rule as VEND.
- flag_key[0] in VEND or DENY aborts immediately to READY/IDLE by the ready rule. If flag_key[0] and flag_key[3] arrive in the same cycle, cancel wins.
- flag_key[3] is ignored in VEND and DENY. It does not restart the flash.
- rNum changes during VEND/DENY do not alter the flash. They only affect the exit target.
- Tick prescaler:
  - Free-running in all states.
  - The tick and chaser counters are not reset on state change.
  - The flash counters are reset on entry to VEND/DENY.

## Timing
- Reset values: led = 0, busy = 0, state = IDLE, all counters 0, chaser = bit 0.
- All outputs are registered.
- A key pulse sampled at edge t gives the new state and its first led pattern after edge t. busy rises at the same edge.
- ready is computed combinationally and registered with the state. A rNum change at edge t shows on led after edge t+1 at most.
- The first flash half-period may be short by up to one tick period, because the prescaler is not realigned. Every later half-period is exact.
- A flash's final half-period ends at the tick that completes the count. The exit state is applied at the same edge, and busy falls at that edge.
- Asynchronous reset mid-flash forces all reset values immediately. No flash resumes after reset.

## Structure
- Package led_status_pkg holds:
  - the state enum (IDLE, READY, VEND, DENY);
  - default timing constants;
  - the vend/cancel key index constants (3, 0).
- Sub-module led_tick_gen (parameter TICK_DIV) outputs a one-cycle tick pulse. Its counter width is $clog2(TICK_DIV).
- The main block contains the FSM, a shared half-period tick counter (width $clog2(max(SLOW_TICKS, FAST_TICKS))), the half-period count, the phase bit and the chaser register.

## Test plan
Bench parameters: N_LED=4, TICK_DIV=4, SLOW_TICKS=4, FAST_TICKS=2, VEND_HALVES=6, DENY_HALVES=4, PRICE=16'h0300.
- Reset, rNum=0, IDLE_CHASE=1: led = 0001 and steps 0010, 0100, 1000, 0001 every 16 clocks; busy = 0.
- rNum=24'h000300: led = 1111 within 2 clocks. rNum=24'h000299: led returns to the IDLE pattern within 2 clocks.
- READY, then a flag_key[3] pulse: busy = 1 and led = 1111 next edge. led alternates 1111/0000 six times at roughly 8-clock halves, then returns to 1111 with busy = 0.
- IDLE, then flag_key[3]: led = 0101/1010 alternating for 4 halves of roughly 16 clocks, then back to chaser with busy = 0.
- VEND, then flag_key[0] and flag_key[3] in the same cycle: flash aborts next edge and led = 1111. Also check a second flag_key[3] mid-flash does not extend the flash.
- Assert rst_n low mid-DENY: led = 0 and busy = 0 asynchronously. After release, state is IDLE with chaser at 0001.
